// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display with
// frame-aligned shadow buffers, per-digit blinking and anti-ghost guard cycles.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PC_W = $clog2(SCAN_DIV);
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0] PC_GUARD = PC_W'(GUARD);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [PC_W-1:0] pc;
  logic [1:0]      idx;
  logic [BC_W-1:0] blinkCnt;
  logic            blinkOff;

  logic [3:0][3:0] digSh;
  logic [3:0]      dpSh;
  logic [3:0]      bmSh;

  logic            tick;
  logic            frameWrap;
  logic            lit;
  logic            blank;
  logic [6:0]      segDec;

  assign tick      = (pc == PC_LAST);
  assign frameWrap = tick && (idx == 2'd3);

  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates see the pre-edge values of their peers, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      idx <= '0;
    end else if (tick) begin
      pc  <= '0;
      idx <= idx + 2'd1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  // NOTE: the shadow buffers are ordinary flops, not a RAM, and are reset so the
  // first frame after reset shows "0000" instead of whatever powered up.
  always_ff @(posedge clk) begin
    if (reset) begin
      digSh <= '0;
      dpSh  <= '0;
      bmSh  <= '0;
    end else if (frameWrap) begin
      digSh <= digits_in;
      dpSh  <= dp_in;
      bmSh  <= blink_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blinkCnt <= '0;
      blinkOff <= 1'b0;
    end else if (frameWrap) begin
      if (blinkCnt == BC_LAST) begin
        blinkCnt <= '0;
        blinkOff <= ~blinkOff;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  assign lit   = en && (pc >= PC_GUARD);
  assign blank = ~lit | (bmSh[idx] & blinkOff);

  // NOTE: segDec gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    segDec = 7'h3F;
    case (digSh[idx])
      4'd0:    segDec = 7'h40;
      4'd1:    segDec = 7'h79;
      4'd2:    segDec = 7'h24;
      4'd3:    segDec = 7'h30;
      4'd4:    segDec = 7'h19;
      4'd5:    segDec = 7'h12;
      4'd6:    segDec = 7'h02;
      4'd7:    segDec = 7'h78;
      4'd8:    segDec = 7'h00;
      4'd9:    segDec = 7'h10;
      default: segDec = 7'h3F;
    endcase
  end

  // Registered pins; frame_start is asserted in the cycle whose state is slot 0, pc 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode       <= 4'b1111;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode       <= lit ? ~(4'b0001 << idx) : 4'b1111;
      seg         <= blank ? 7'h7F : segDec;
      dp          <= blank ? 1'b1 : ~dpSh[idx];
      frame_start <= frameWrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a cycle-count based display model
// checked every cycle, plus hand-computed literal expectations.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV     = 4;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 4 * SCAN_DIV;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int numChecks = 0;
  int numPass   = 0;

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .GUARD       (GUARD),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act === exp) numPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Model: cycle n after reset lies in frame n/FRAME_LEN, digit (n/SCAN_DIV)%4 and
  // position n%SCAN_DIV; pins show cycle n's picture one edge later.
  int          edgeCount = 0;
  logic [15:0] mDig;
  logic [3:0]  mDp;
  logic [3:0]  mBm;
  logic [3:0]  expAnode;
  logic [6:0]  expSeg;
  logic        expDp;
  logic        expFs;

  always @(posedge clk) begin
    if (reset) begin
      edgeCount = 0;
      mDig = '0; mDp = '0; mBm = '0;
      expAnode = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expFs = 1'b0;
    end else begin
      int n, frame, digit, pos;
      logic isLit, isBlank, blinkPhase;
      n          = edgeCount;
      edgeCount  = edgeCount + 1;
      frame      = n / FRAME_LEN;
      digit      = (n / SCAN_DIV) % 4;
      pos        = n % SCAN_DIV;
      blinkPhase = ((frame / BLINK_FRAMES) % 2) == 1;
      isLit      = en && (pos >= GUARD);
      isBlank    = !isLit || (mBm[digit] && blinkPhase);
      expAnode   = isLit ? ~(4'(1) << digit) : 4'hF;
      expSeg     = isBlank ? 7'h7F : dec7(mDig[digit*4 +: 4]);
      expDp      = isBlank ? 1'b1 : ~mDp[digit];
      expFs      = (edgeCount % FRAME_LEN) == 0;
      if ((edgeCount % FRAME_LEN) == 0) begin
        mDig = digits_in; mDp = dp_in; mBm = blink_mask;
      end
    end
    #1;
    check("anode", anode, expAnode);
    check("seg", seg, expSeg);
    check("dp", dp, expDp);
    check("frame_start", frame_start, expFs);
  end

  task automatic goTo(input int target);
    int guardCnt = 0;
    while (edgeCount != target) begin
      @(negedge clk);
      guardCnt++;
      if (guardCnt > 2000) begin
        check("goTo_bound", guardCnt, 0);
        return;
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    reset = 1'b0;

    goTo(1);  check("f0_guard_anode", anode, 4'hF);
    goTo(2);  check("f0_anode", anode, 4'hE); check("f0_seg", seg, 7'h40);
    goTo(16); check("fs_16", frame_start, 1'b1);
    goTo(17); check("fs_17", frame_start, 1'b0);
    goTo(18); check("f1_d0_seg", seg, 7'h19); check("f1_d0_anode", anode, 4'hE);
    goTo(22); check("f1_d1_seg", seg, 7'h30); check("f1_d1_anode", anode, 4'hD);
    goTo(26); check("f1_d2_seg", seg, 7'h24);
    goTo(30); check("f1_d3_seg", seg, 7'h79); check("f1_d3_anode", anode, 4'h7);
    goTo(32); check("fs_32", frame_start, 1'b1);

    goTo(37); digits_in = 16'h9999;
    goTo(46); check("midframe_hold", seg, 7'h79);
    goTo(50); check("f3_9999", seg, 7'h10);
    blink_mask = 4'b0011;
    goTo(66); check("f4_shown", seg, 7'h10);
    goTo(98); check("f6_d0_blank", seg, 7'h7F); check("f6_d0_anode", anode, 4'hE);
    goTo(102); check("f6_d1_blank", seg, 7'h7F);
    goTo(106); check("f6_d2_shown", seg, 7'h10); check("f6_d2_anode", anode, 4'hB);
    goTo(130); check("f8_d0_shown", seg, 7'h10);

    goTo(138); check("pre_en_anode", anode, 4'hB);
    en = 1'b0;
    goTo(139); check("en_off_anode", anode, 4'hF);
    goTo(148); check("en_off_hold", anode, 4'hF);
    en = 1'b1;
    goTo(150); check("en_resume_anode", anode, 4'hD); check("en_resume_seg", seg, 7'h10);

    goTo(152); digits_in = 16'h9B99; dp_in = 4'b0100; blink_mask = 4'b0000;
    goTo(169); check("dp_guard", dp, 1'b1); check("dp_guard_anode", anode, 4'hF);
    goTo(170); check("hex_b_seg", seg, 7'h3F); check("dp_lit", dp, 1'b0); check("d2_anode", anode, 4'hB);
    goTo(174); check("d3_dp_off", dp, 1'b1);

    goTo(180); reset = 1'b1;
    @(negedge clk);
    check("midrst_anode", anode, 4'hF); check("midrst_seg", seg, 7'h7F);
    reset = 1'b0;
    goTo(2);  check("post_rst_seg", seg, 7'h40); check("post_rst_anode", anode, 4'hE);
    goTo(40);

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
